mux_scan_nx1: RTL and testbench
===============================

# mux_scan_nx1

Parametrised N:1 registered multiplexer, the successor to the lab's fixed 4:1 combinational mux. It selects one of CHANNELS data lanes, each WIDTH bits wide, and registers the result. It has two selection modes: manual, where Sel drives the choice, and auto-scan, where an internal counter steps through the channels and dwells DWELL cycles on each. It sits between multi-source datapaths and a single downstream consumer, such as a display or shared bus, and flags each output word with ZValid.

## Interface
- WIDTH, 1: bits per channel.
- CHANNELS, 4: number of input channels, ≥2, not necessarily a power of two.
- DWELL, 4: cycles spent on each channel in scan mode, ≥1.
- SW = $clog2(CHANNELS): derived select width, not overridable.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Data  in  CHANNELS*WIDTH  packed lanes; channel k occupies Data[k*WIDTH +: WIDTH].
- Sel  in  SW  manual channel select; also the scan start channel.
- Mode  in  1  0 = manual, 1 = scan.
- Enable  in  1  0 forces the IDLE state.
- Z  out  WIDTH  registered selected lane.
- ZValid  out  1  Z holds valid data from a legal channel.
- ChanOut  out  SW  channel index that produced the current Z.

## Operation
FSM states are IDLE, MANUAL and SCAN. Transitions are evaluated every cycle, with priority from top to bottom:
- Enable=0 → IDLE.
- Enable=1, Mode=0 → MANUAL.
- Enable=1, Mode=1 → SCAN.

Per-state behaviour:
- IDLE: Z, ChanOut and the counters hold; ZValid=0.
- MANUAL: each cycle, Z ← Data[Sel], ChanOut ← Sel, ZValid ← 1.
- SCAN entry, from any other state: channel counter ← Sel and dwell counter ← 0. Z ← Data[Sel] in that same cycle.
- SCAN steady state:
  - The dwell counter increments every cycle.
  - When it reaches DWELL-1, the dwell counter resets to 0 and the channel counter advances by one.
  - The channel counter wraps from CHANNELS-1 to 0.
  - Z ← Data[channel] is updated every cycle, so data is live during the dwell and not latched once.
- Illegal Sel (Sel ≥ CHANNELS, possible only when CHANNELS is not a power of two):
  - In MANUAL: Z ← 0 and ZValid ← 0.
  - On SCAN entry: the start channel is 0.
- Mode toggling mid-scan: takes effect on the next edge. Returning to SCAN always re-enters from Sel.
- Arithmetic: both counters are unsigned. The dwell counter is $clog2(DWELL+1) bits wide. No overflow beyond the wrap rules above.

## Timing
- Latency is 1 cycle: Data, Sel, Mode and Enable sampled at edge n appear on Z, ZValid and ChanOut after edge n.
- No combinational path from any input to any output.
- Reset (asserted at any time, including mid-scan): Z=0, ZValid=0, ChanOut=0, state=IDLE, both counters=0.
- Release: the first update is on the first rising edge with Rst_n=1.
- DWELL=1: the channel advances every cycle in SCAN.
- Enable deasserted mid-dwell: the counters freeze. Re-enabling SCAN restarts from Sel; it does not resume.

## Configuration
- MUX_SCAN_MASK_EN defined:
  - Adds input port Mask (CHANNELS bits, 1 = channel enabled).
  - SCAN skips masked-off channels. The advance goes to the next enabled channel in ascending order, with wrap.
  - SCAN entry on a masked channel goes to the next enabled channel in that same cycle.
  - Mask=0 while in SCAN: ZValid=0 and Z holds.
  - MANUAL ignores Mask.
- MUX_SCAN_MASK_EN not defined: no Mask port, and all channels are scanned.

## Structure
- Package mux_scan_pkg holds:
  - the state enum (IDLE, MANUAL, SCAN);
  - a helper function for the next enabled channel with wrap.
- Sub-module mux_scan_ctrl holds the FSM, the dwell counter and the channel counter, and outputs the channel index and a valid flag.
- The top level holds the lane-select and output registers.

## Test plan
- Defaults (WIDTH=1, CHANNELS=4), Data=4'b1010, Mode=0, Enable=1, Sel stepping 0,1,2,3 every 10 cycles → one cycle after each change Z reads 0,1,0,1, ChanOut matches Sel, ZValid=1.
- Mode=1, DWELL=4, Sel=2 → ChanOut sequence: 2 for 4 cycles, then 3×4, 0×4, 1×4, 2×4. Verifies wrap.
- Rst_n pulsed low mid-scan → Z, ZValid and ChanOut go to 0 asynchronously. After release with Enable=1, Mode=1, Sel=1 → ChanOut=1 one edge later.
- CHANNELS=3, Mode=0, Sel=3 → ZValid=0 and Z=0. Switching to Mode=1 → scan starts at channel 0.
- MUX_SCAN_MASK_EN with Mask=4'b0101 in SCAN from Sel=0 → ChanOut goes 0,2,0,2, each held DWELL cycles. Then Mask=0 → ZValid=0 one edge later and Z holds.
- Enable dropped for 3 cycles mid-dwell → ZValid=0 during IDLE. On re-enable in SCAN, ChanOut=Sel and a full DWELL elapses before it advances.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the N:1 scan mux (state encoding, masked channel search).
// Pure declarations; no clocked logic here.
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;

  // Mask vectors are zero-extended to this width so one helper serves any CHANNELS.
  localparam int MAX_CH = 64;
  localparam int MAX_CW = 6;

  // Nearest enabled channel at or after cur (incl=1) or strictly after it (incl=0), wrapping at n.
  function automatic int next_chan(input logic [MAX_CH-1:0] mask, input int cur,
                                   input int n, input bit incl);
    int  c;
    int  res;
    bit  found;
    res   = cur;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (!found && i < n) begin
        c = cur + i + (incl ? 0 : 1);
        if (c >= n) c = c - n;
        if (mask[c[MAX_CW-1:0]]) begin
          res   = c;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Selection FSM with dwell and channel counters; emits the channel to load next edge.
// Outputs are combinational from inputs and state; the top registers them (1-cycle latency).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                mode_i,
  input  logic [SW-1:0]       sel_i,
  input  logic [CHANNELS-1:0] mask_i,
  output logic [SW-1:0]       chan_o,
  output logic                vld_o,
  output logic                upd_o
);

  localparam int DW = $clog2(DWELL + 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     chan_q, chan_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [MAX_CH-1:0] mask_ext;
  logic              sel_legal;
  logic [SW-1:0]     start;

  always_comb begin
    mask_ext                 = '0;
    mask_ext[CHANNELS-1:0]   = mask_i;
    sel_legal                = int'(sel_i) < CHANNELS;
    start                    = sel_legal ? sel_i : '0;

    state_d = state_q;
    chan_d  = chan_q;
    dwell_d = dwell_q;
    chan_o  = chan_q;
    vld_o   = 1'b0;
    upd_o   = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
    end else if (!mode_i) begin
      state_d = MANUAL;
      chan_o  = sel_i;
      upd_o   = 1'b1;
      vld_o   = sel_legal;
    end else begin
      state_d = SCAN;
      // With every channel masked off nothing is selectable: hold counters and output.
      if (|mask_i) begin
        if (state_q != SCAN) begin
          chan_d  = SW'(next_chan(mask_ext, int'(start), CHANNELS, 1'b1));
          dwell_d = '0;
        end else if (dwell_q == DW'(DWELL - 1)) begin
          chan_d  = SW'(next_chan(mask_ext, int'(chan_q), CHANNELS, 1'b0));
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
        chan_o = chan_d;
        upd_o  = 1'b1;
        vld_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      chan_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 mux with manual or auto-scan selection; 1-cycle latency, no backpressure.
// MUX_SCAN_MASK_EN adds a Mask port so scan mode skips disabled channels.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       Mask,
`endif
  input  logic [CHANNELS*WIDTH-1:0] Data,
  input  logic [SW-1:0]             Sel,
  input  logic                      Mode,
  input  logic                      Enable,
  output logic [WIDTH-1:0]          Z,
  output logic                      ZValid,
  output logic [SW-1:0]             ChanOut
);

  logic [CHANNELS-1:0] mask_en;
  logic [SW-1:0]       sel_chan;
  logic                sel_vld;
  logic                sel_upd;
  logic [WIDTH-1:0]    lane;
  logic [WIDTH-1:0]    z_q, z_d;
  logic                zvalid_q, zvalid_d;
  logic [SW-1:0]       chan_out_q, chan_out_d;

`ifdef MUX_SCAN_MASK_EN
  assign mask_en = Mask;
`else
  assign mask_en = '1;
`endif

  mux_scan_ctrl #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ctrl (
    .clk_i    (Clk),
    .rst_ni   (Rst_n),
    .enable_i (Enable),
    .mode_i   (Mode),
    .sel_i    (Sel),
    .mask_i   (mask_en),
    .chan_o   (sel_chan),
    .vld_o    (sel_vld),
    .upd_o    (sel_upd)
  );

  always_comb begin
    lane = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_chan == SW'(k)) lane = Data[k*WIDTH +: WIDTH];
    end

    z_d        = z_q;
    chan_out_d = chan_out_q;
    zvalid_d   = sel_vld;
    // An update without a valid channel (illegal manual select) clears the word.
    if (sel_upd) begin
      z_d        = sel_vld ? lane : '0;
      chan_out_d = sel_chan;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      z_q        <= '0;
      zvalid_q   <= 1'b0;
      chan_out_q <= '0;
    end else begin
      z_q        <= z_d;
      zvalid_q   <= zvalid_d;
      chan_out_q <= chan_out_d;
    end
  end

  assign Z       = z_q;
  assign ZValid  = zvalid_q;
  assign ChanOut = chan_out_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: default 4-channel instance plus a 3-channel instance.
module tb_mux_scan_nx1;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;

  logic [3:0]  data_a = '0;
  logic [1:0]  sel_a = '0;
  logic        mode_a = 1'b0;
  logic        en_a = 1'b0;
  logic [0:0]  z_a;
  logic        zv_a;
  logic [1:0]  ch_a;

  logic [11:0] data_b = '0;
  logic [1:0]  sel_b = '0;
  logic        mode_b = 1'b0;
  logic        en_b = 1'b0;
  logic [3:0]  z_b;
  logic        zv_b;
  logic [1:0]  ch_b;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  mask_a = 4'b1111;
  logic [2:0]  mask_b = 3'b111;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 Clk = ~Clk;

  mux_scan_nx1 #(.WIDTH(1), .CHANNELS(4), .DWELL(4)) dut_a (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
`ifdef MUX_SCAN_MASK_EN
    .Mask    (mask_a),
`endif
    .Data    (data_a),
    .Sel     (sel_a),
    .Mode    (mode_a),
    .Enable  (en_a),
    .Z       (z_a),
    .ZValid  (zv_a),
    .ChanOut (ch_a)
  );

  mux_scan_nx1 #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) dut_b (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
`ifdef MUX_SCAN_MASK_EN
    .Mask    (mask_b),
`endif
    .Data    (data_b),
    .Sel     (sel_b),
    .Mode    (mode_b),
    .Enable  (en_b),
    .Z       (z_b),
    .ZValid  (zv_b),
    .ChanOut (ch_b)
  );

  typedef struct {
    logic [3:0] data;
    logic [1:0] sel;
    logic       mode;
    logic       en;
    logic       z;
    logic       zv;
    logic [1:0] ch;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_ch;
    logic       last_z;

    vecs[0] = '{4'b1010, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{4'b1010, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[2] = '{4'b1010, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[3] = '{4'b1010, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3};
    vecs[4] = '{4'b0110, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[5] = '{4'b0110, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3};
    vecs[6] = '{4'b1111, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
    vecs[7] = '{4'b1111, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};

    // reset state
    #1 Rst_n = 1'b0;
    #1;
    check("rst_z", z_a, 0);
    check("rst_zv", zv_a, 0);
    check("rst_ch", ch_a, 0);
    tick();
    Rst_n = 1'b1;

    // manual table, one edge per vector
    for (int i = 0; i < 8; i++) begin
      data_a = vecs[i].data;
      sel_a  = vecs[i].sel;
      mode_a = vecs[i].mode;
      en_a   = vecs[i].en;
      tick();
      check($sformatf("vec%0d_z", i), z_a, vecs[i].z);
      check($sformatf("vec%0d_zv", i), zv_a, vecs[i].zv);
      check($sformatf("vec%0d_ch", i), ch_a, vecs[i].ch);
    end

    // no combinational path: a mid-cycle Sel change must not reach ChanOut
    sel_a = 2'd1;
    #2;
    check("nocomb_ch", ch_a, 2);

    // scan from Sel=2 with wrap; data changed mid-dwell, Sel changed mid-scan
    data_a = 4'b1010;
    sel_a  = 2'd2;
    mode_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) data_a = 4'b0101;
      if (i == 9) sel_a = 2'd0;
      tick();
      exp_ch = 2'((2 + i / 4) % 4);
      check($sformatf("scan%0d_ch", i), ch_a, exp_ch);
      check($sformatf("scan%0d_z", i), z_a, data_a[exp_ch]);
      check($sformatf("scan%0d_zv", i), zv_a, 1);
    end

    // enable dropped mid-dwell: freeze, then restart from Sel with a full dwell
    en_a = 1'b0;
    tick();
    check("idle_zv", zv_a, 0);
    data_a = 4'b0010;
    sel_a  = 2'd1;
    en_a   = 1'b1;
    tick();
    check("reen_entry_ch", ch_a, 1);
    tick();
    check("reen_dwell_ch", ch_a, 1);
    en_a   = 1'b0;
    data_a = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle%0d_zv", i), zv_a, 0);
      check($sformatf("idle%0d_ch", i), ch_a, 1);
      check($sformatf("idle%0d_z", i), z_a, 1);
    end
    en_a   = 1'b1;
    sel_a  = 2'd3;
    data_a = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("restart%0d_ch", i), ch_a, 3);
      check($sformatf("restart%0d_z", i), z_a, 1);
    end
    tick();
    check("restart_adv_ch", ch_a, 0);
    check("restart_adv_z", z_a, 0);

    // asynchronous reset mid-scan
    data_a = 4'b1111;
    for (int i = 0; i < 4; i++) tick();
    check("prerst_ch", ch_a, 1);
    check("prerst_z", z_a, 1);
    #3 Rst_n = 1'b0;
    #1;
    check("arst_z", z_a, 0);
    check("arst_zv", zv_a, 0);
    check("arst_ch", ch_a, 0);
    tick();
    check("arst_hold_zv", zv_a, 0);
    sel_a  = 2'd1;
    mode_a = 1'b1;
    en_a   = 1'b1;
    Rst_n  = 1'b1;
    tick();
    check("release_ch", ch_a, 1);
    check("release_zv", zv_a, 1);
    check("release_z", z_a, 1);

`ifdef MUX_SCAN_MASK_EN
    en_a = 1'b0;
    tick();
    mask_a = 4'b0101;
    sel_a  = 2'd0;
    data_a = 4'b0100;
    en_a   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_ch = ((i / 4) % 2 == 1) ? 2'd2 : 2'd0;
      check($sformatf("mask%0d_ch", i), ch_a, exp_ch);
      check($sformatf("mask%0d_z", i), z_a, data_a[exp_ch]);
    end
    last_z = z_a;
    mask_a = 4'b0000;
    data_a = 4'b0000;
    tick();
    check("mask0_zv", zv_a, 0);
    check("mask0_z", z_a, last_z);
    en_a = 1'b0;
    tick();
    mask_a = 4'b0101;
    sel_a  = 2'd1;
    en_a   = 1'b1;
    tick();
    check("mask_entry_ch", ch_a, 2);
`else
    last_z = 1'b0;
`endif

    // 3-channel instance: illegal select, then scan from illegal Sel starts at 0
    data_b = 12'hCA5;
    mode_b = 1'b0;
    en_b   = 1'b1;
    sel_b  = 2'd2;
    tick();
    check("b_man2_z", z_b, 4'hC);
    check("b_man2_zv", zv_b, 1);
    sel_b = 2'd3;
    tick();
    check("b_ill_z", z_b, 0);
    check("b_ill_zv", zv_b, 0);
    mode_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_ch = 2'((i / 2) % 3);
      check($sformatf("b_scan%0d_ch", i), ch_b, exp_ch);
      check($sformatf("b_scan%0d_z", i), z_b, data_b[exp_ch*4 +: 4]);
      check($sformatf("b_scan%0d_zv", i), zv_b, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
